// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types for the instruction fetch slice: the fetch FSM state
// encoding, datapath widths, and the decode buffer entry layout.
package fetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Two-entry decode buffer. Entry 0 is always the head, so the head
// outputs come straight from a register; a pop shifts entry 1 down.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   push      write din this cycle (ignored when full and not popping)
//   pop       retire the head this cycle (ignored when empty)
//   flush     empty the buffer; wins over push and pop
//   din       entry to write
//   head      current head entry
//   count     number of valid entries (0..2)
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  fifo_entry_t din,
  output fifo_entry_t head,
  output logic [1:0]  count
);

  fifo_entry_t mem [2];
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[0];

  // Simultaneous push and pop keep the count; the new entry lands in
  // whichever slot sits behind the surviving entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          mem[count[0]] <= din;
          count         <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            mem[0] <= din;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Owns the PC, issues word-indexed fetches to instruction memory (data
// returns one cycle later), buffers responses for decode, handles
// redirects from execute and halts on an out-of-range PC.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   start                 pulse to leave IDLE
//   im_pc, im_req         fetch address and request strobe
//   im_instr              memory data, valid the cycle after im_req
//   redir_valid, redir_pc redirect request and target
//   out_valid, out_ready  decode handshake
//   out_instr, out_pc     head instruction and its word index
//   fault                 sticky out-of-range flag
//   busy                  FSM not in IDLE
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'd10,
  parameter int          MEM_WORDS  = 262144,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    im_pc,
  output logic               im_req,
  input  logic [INSTR_W-1:0] im_instr,
  input  logic               redir_valid,
  input  logic [PC_W-1:0]    redir_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               fault,
  output logic               busy
);

  localparam logic [PC_W-1:0] MEM_LIMIT = PC_W'(MEM_WORDS);
  localparam logic [2:0]      DEPTH     = 3'(FIFO_DEPTH);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] tag_pc;
  logic            inflight;
  logic            redirect;
  logic            fault_set;
  logic            push;
  logic            pop;
  logic [2:0]      credit;
  logic [1:0]      count;
  fifo_entry_t     head;

  assign pop       = out_valid && out_ready;
  assign im_pc     = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign busy      = (state != IDLE);

  // Occupancy seen by the issue check: buffered entries plus the one in
  // flight, less the head decode is taking this cycle. Counting the pop
  // keeps a ready consumer fed every cycle without ever overfilling.
  assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

  // A response is dropped when a redirect lands on the same cycle or
  // while flushing; otherwise it joins the buffer with its tag.
  assign push = inflight && !redirect && (state != FLUSH);

  // Next-state, issue and redirect decisions.
  always_comb begin
    state_nxt = state;
    im_req    = 1'b0;
    redirect  = 1'b0;
    fault_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (redir_valid) begin
          redirect  = 1'b1;
          state_nxt = inflight ? FLUSH : RUN;
        end else if (credit < DEPTH) begin
          if (pc >= MEM_LIMIT) begin
            fault_set = 1'b1;
            state_nxt = HALT;
          end else begin
            im_req = 1'b1;
          end
        end
      end
      FLUSH: begin
        redirect  = redir_valid;
        state_nxt = RUN;
      end
      HALT: ;
      default: state_nxt = IDLE;
    endcase
  end

  // State, PC and in-flight tracking. Memory answers exactly one cycle
  // after a request, so in-flight simply mirrors last cycle's im_req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= im_req;
      if (im_req) begin
        pc     <= pc + 64'd1;
        tag_pc <= pc;
      end else if (redirect) begin
        pc <= redir_pc;
      end
      if (fault_set) fault <= 1'b1;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ('{pc: tag_pc, instr: im_instr}),
    .head  (head),
    .count (count)
  );

endmodule
